// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator: data width, register offsets
// within the 16-word window, and the default ID readback value.
package pwm_pkg;

    localparam int          DATA_W         = 16;
    localparam logic [15:0] ID_DEFAULT     = 16'h5057;

    localparam logic [3:0]  ADDR_CTRL      = 4'h0;
    localparam logic [3:0]  ADDR_ENABLE    = 4'h1;
    localparam logic [3:0]  ADDR_POLARITY  = 4'h2;
    localparam logic [3:0]  ADDR_PRESCALE  = 4'h3;
    localparam logic [3:0]  ADDR_PERIOD    = 4'h4;
    localparam logic [3:0]  ADDR_COUNT     = 4'h5;
    localparam logic [3:0]  ADDR_ID        = 4'h6;
    localparam logic [3:0]  ADDR_DUTY_BASE = 4'h8;

endpackage

// File: rtl/pwm_gen_if.sv
// Host-bus slave port of the PWM block, as seen from the address decoder.
interface pwm_gen_if;
    import pwm_pkg::*;

    logic              pwm_cs;
    logic [DATA_W-1:0] pwm_addr;
    logic [DATA_W-1:0] pwm_wr_data;
    logic              pwm_wr_en;
    logic              pwm_rd_en;
    logic [DATA_W-1:0] pwm_rd_data;

    modport master (
        output pwm_cs, pwm_addr, pwm_wr_data, pwm_wr_en, pwm_rd_en,
        input  pwm_rd_data
    );

    modport slave (
        input  pwm_cs, pwm_addr, pwm_wr_data, pwm_wr_en, pwm_rd_en,
        output pwm_rd_data
    );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus shared period counter. The active period copy only
// reloads from the shadow at a wrap (or continuously while stopped), so a
// period change never cuts a running period short.
module pwm_timebase
    import pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] prescale,
    input  logic [DATA_W-1:0] period_sh,
    output logic [DATA_W-1:0] count,
    output logic              reload,
    output logic              period_strb
);

    logic [DATA_W-1:0] ps_cnt;
    logic [DATA_W-1:0] per_act;
    logic              tick;
    logic              wrap;

    // Prescale is compared against the live register, so a smaller value
    // written mid-count lets ps_cnt run on through 16'hFFFF before matching.
    assign tick   = run && (ps_cnt == prescale);
    assign wrap   = tick && (count == per_act);
    assign reload = !run || wrap;

    // Prescaler, period counter, active period copy and wrap strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt      <= '0;
            count       <= '0;
            per_act     <= '0;
            period_strb <= 1'b0;
        end else if (!run) begin
            ps_cnt      <= '0;
            count       <= '0;
            per_act     <= period_sh;
            period_strb <= 1'b0;
        end else begin
            period_strb <= wrap;
            if (tick) begin
                ps_cnt <= '0;
                if (wrap) begin
                    count   <= '0;
                    per_act <= period_sh;
                end else begin
                    count <= count + 16'd1;
                end
            end else begin
                ps_cnt <= ps_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: register file on the host bus, shared timebase, and one
// registered compare per channel with period-synchronised duty updates.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int          N_CH     = 3,
    parameter logic [15:0] ID_VALUE = ID_DEFAULT
) (
    input  logic            host_clk,
    input  logic            host_rst,
    pwm_gen_if.slave        bus,
    output logic [N_CH-1:0] pwm_out,
    output logic            pwm_period_strb
);

    logic              run_q;
    logic [N_CH-1:0]   enable_q;
    logic [N_CH-1:0]   polarity_q;
    logic [DATA_W-1:0] prescale_q;
    logic [DATA_W-1:0] period_sh;
    logic [DATA_W-1:0] duty_sh [N_CH];
    logic [DATA_W-1:0] count;
    logic              reload;
    logic              wr;
    logic              stop_wr;
    logic              run_eff;
    logic [3:0]        reg_addr;
    logic              unused_bits;

    assign reg_addr    = bus.pwm_addr[3:0];
    assign wr          = bus.pwm_cs && bus.pwm_wr_en;
    // Clearing RUN stops the counters on the very edge of the write.
    assign stop_wr     = wr && (reg_addr == ADDR_CTRL) && !bus.pwm_wr_data[0];
    assign run_eff     = run_q && !stop_wr;
    assign unused_bits = ^{bus.pwm_rd_en, bus.pwm_addr[15:4]};

    // Control and shared shadow registers.
    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            run_q      <= 1'b0;
            enable_q   <= '0;
            polarity_q <= '0;
            prescale_q <= '0;
            period_sh  <= '0;
        end else if (wr) begin
            case (reg_addr)
                ADDR_CTRL:     run_q      <= bus.pwm_wr_data[0];
                ADDR_ENABLE:   enable_q   <= bus.pwm_wr_data[N_CH-1:0];
                ADDR_POLARITY: polarity_q <= bus.pwm_wr_data[N_CH-1:0];
                ADDR_PRESCALE: prescale_q <= bus.pwm_wr_data;
                ADDR_PERIOD:   period_sh  <= bus.pwm_wr_data;
                default: ;
            endcase
        end
    end

    pwm_timebase u_timebase (
        .clk         (host_clk),
        .rst         (host_rst),
        .run         (run_eff),
        .prescale    (prescale_q),
        .period_sh   (period_sh),
        .count       (count),
        .reload      (reload),
        .period_strb (pwm_period_strb)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [3:0] DUTY_ADDR = ADDR_DUTY_BASE + 4'(i);
        logic [DATA_W-1:0] duty_act;
        logic              out_r;

        // Duty shadow, active copy taken at wrap, and registered pin level.
        always_ff @(posedge host_clk) begin
            if (host_rst) begin
                duty_sh[i] <= '0;
                duty_act   <= '0;
                out_r      <= 1'b0;
            end else begin
                if (wr && (reg_addr == DUTY_ADDR)) begin
                    duty_sh[i] <= bus.pwm_wr_data;
                end
                if (reload) begin
                    duty_act <= duty_sh[i];
                end
                out_r <= polarity_q[i] ^ (run_q & enable_q[i] & (count < duty_act));
            end
        end

        assign pwm_out[i] = out_r;
    end

    // Zero-latency read mux feeding the decoder's own combinational mux.
    always_comb begin
        bus.pwm_rd_data = '0;
        if (bus.pwm_cs) begin
            case (reg_addr)
                ADDR_CTRL:     bus.pwm_rd_data[0]        = run_q;
                ADDR_ENABLE:   bus.pwm_rd_data[N_CH-1:0] = enable_q;
                ADDR_POLARITY: bus.pwm_rd_data[N_CH-1:0] = polarity_q;
                ADDR_PRESCALE: bus.pwm_rd_data           = prescale_q;
                ADDR_PERIOD:   bus.pwm_rd_data           = period_sh;
                ADDR_COUNT:    bus.pwm_rd_data           = count;
                ADDR_ID:       bus.pwm_rd_data           = ID_VALUE;
                default: begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (reg_addr == ADDR_DUTY_BASE + 4'(k)) begin
                            bus.pwm_rd_data = duty_sh[k];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: register table, waveform shape, duty update
// timing, limits/polarity, stop and mid-run reset.
module tb_pwm_gen;
    import pwm_pkg::*;

    logic       host_clk = 1'b0;
    logic       host_rst;
    logic [2:0] pwm_out;
    logic       pwm_period_strb;
    int         n_checks = 0;
    int         n_errors = 0;

    pwm_gen_if bus();

    pwm_gen #(.N_CH(3), .ID_VALUE(16'h5057)) dut (
        .host_clk        (host_clk),
        .host_rst        (host_rst),
        .bus             (bus),
        .pwm_out         (pwm_out),
        .pwm_period_strb (pwm_period_strb)
    );

    always #5 host_clk = ~host_clk;

    typedef struct {
        logic [3:0]  addr;
        logic [1:0]  wr_mode;   // 0 none, 1 write with cs, 2 strobe without cs
        logic [15:0] wdata;
        logic        rd_cs;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_rst_vecs;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge host_clk);
    endtask

    task automatic wr_cs(input logic cs, input logic [3:0] a, input logic [15:0] d);
        bus.pwm_cs      = cs;
        bus.pwm_addr    = {12'h4A0, a};
        bus.pwm_wr_data = d;
        bus.pwm_wr_en   = 1'b1;
        @(negedge host_clk);
        bus.pwm_cs      = 1'b0;
        bus.pwm_wr_en   = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_cs(1'b1, a, d);
    endtask

    task automatic rd(input logic cs, input logic [3:0] a, output logic [15:0] d);
        bus.pwm_cs    = cs;
        bus.pwm_addr  = {12'h4A0, a};
        bus.pwm_rd_en = 1'b1;
        #1;
        d = bus.pwm_rd_data;
        bus.pwm_cs    = 1'b0;
        bus.pwm_rd_en = 1'b0;
    endtask

    task automatic wait_count(input logic [15:0] v, input string name);
        logic [15:0] d;
        int k;
        for (k = 0; k < 200; k++) begin
            rd(1'b1, ADDR_COUNT, d);
            if (d == v) break;
            @(negedge host_clk);
        end
        if (k == 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: COUNT never reached %0d", name, v);
        end
    endtask

    // Measures one high pulse and the following low gap of a channel.
    task automatic measure(input int ch, input bit at_rise, input int exp_hi,
                           input int exp_lo, input string name);
        logic prev;
        int   guard;
        int   hi;
        int   lo;
        if (!at_rise) begin
            prev = pwm_out[ch];
            for (guard = 0; guard < 300; guard++) begin
                @(negedge host_clk);
                if (pwm_out[ch] && !prev) break;
                prev = pwm_out[ch];
            end
            if (guard == 300) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: no rising edge on channel %0d", name, ch);
                return;
            end
        end
        hi = 0;
        while (pwm_out[ch] && hi < 300) begin
            hi++;
            @(negedge host_clk);
        end
        lo = 0;
        while (!pwm_out[ch] && lo < 300) begin
            lo++;
            @(negedge host_clk);
        end
        check({name, "_hi"}, 16'(hi), 16'(exp_hi));
        check({name, "_lo"}, 16'(lo), 16'(exp_lo));
    endtask

    task automatic strobe_gap(input int exp, input string name);
        int g;
        for (g = 0; g < 100 && !pwm_period_strb; g++) @(negedge host_clk);
        g = 0;
        do begin
            @(negedge host_clk);
            g++;
        end while (!pwm_period_strb && g < 100);
        check(name, 16'(g), 16'(exp));
    endtask

    task automatic check_const(input int ch, input logic v, input string name);
        int bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge host_clk);
            if (pwm_out[ch] !== v) bad++;
        end
        check(name, 16'(bad), 16'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int bad;

        bus.pwm_cs = 1'b0; bus.pwm_addr = '0; bus.pwm_wr_data = '0;
        bus.pwm_wr_en = 1'b0; bus.pwm_rd_en = 1'b0;
        host_rst = 1'b1;

        // reset readback vectors
        vecs.push_back('{4'h0, 2'd0, 16'h0000, 1'b1, 16'h0000, "rst_ctrl"});
        vecs.push_back('{4'h1, 2'd0, 16'h0000, 1'b1, 16'h0000, "rst_enable"});
        vecs.push_back('{4'h2, 2'd0, 16'h0000, 1'b1, 16'h0000, "rst_polarity"});
        vecs.push_back('{4'h3, 2'd0, 16'h0000, 1'b1, 16'h0000, "rst_prescale"});
        vecs.push_back('{4'h4, 2'd0, 16'h0000, 1'b1, 16'h0000, "rst_period"});
        vecs.push_back('{4'h5, 2'd0, 16'h0000, 1'b1, 16'h0000, "rst_count"});
        vecs.push_back('{4'h6, 2'd0, 16'h0000, 1'b1, 16'h5057, "rst_id"});
        vecs.push_back('{4'h8, 2'd0, 16'h0000, 1'b1, 16'h0000, "rst_duty0"});
        vecs.push_back('{4'h9, 2'd0, 16'h0000, 1'b1, 16'h0000, "rst_duty1"});
        vecs.push_back('{4'hA, 2'd0, 16'h0000, 1'b1, 16'h0000, "rst_duty2"});
        vecs.push_back('{4'h6, 2'd0, 16'h0000, 1'b0, 16'h0000, "rd_no_cs"});
        n_rst_vecs = vecs.size();
        // write/readback vectors
        vecs.push_back('{4'h1, 2'd1, 16'hFFFF, 1'b1, 16'h0007, "wr_enable"});
        vecs.push_back('{4'h2, 2'd1, 16'hFFFF, 1'b1, 16'h0007, "wr_polarity"});
        vecs.push_back('{4'h3, 2'd1, 16'h1234, 1'b1, 16'h1234, "wr_prescale"});
        vecs.push_back('{4'h4, 2'd1, 16'hABCD, 1'b1, 16'hABCD, "wr_period"});
        vecs.push_back('{4'h5, 2'd1, 16'h5555, 1'b1, 16'h0000, "wr_count_ro"});
        vecs.push_back('{4'h6, 2'd1, 16'h0000, 1'b1, 16'h5057, "wr_id_ro"});
        vecs.push_back('{4'h7, 2'd1, 16'hFFFF, 1'b1, 16'h0000, "wr_hole7"});
        vecs.push_back('{4'h8, 2'd1, 16'h0011, 1'b1, 16'h0011, "wr_duty0"});
        vecs.push_back('{4'hA, 2'd1, 16'h00AA, 1'b1, 16'h00AA, "wr_duty2"});
        vecs.push_back('{4'h9, 2'd2, 16'h9999, 1'b1, 16'h0000, "wr_no_cs"});
        vecs.push_back('{4'hB, 2'd1, 16'hFFFF, 1'b1, 16'h0000, "wr_duty3_absent"});
        vecs.push_back('{4'hF, 2'd1, 16'hFFFF, 1'b1, 16'h0000, "wr_holeF"});
        vecs.push_back('{4'h0, 2'd1, 16'hFFFE, 1'b1, 16'h0000, "wr_ctrl_bit0"});

        step(3);
        host_rst = 1'b0;
        step(1);
        check("rst_pwm_out", 16'(pwm_out), 16'h0000);

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].wr_mode == 2'd1) wr_cs(1'b1, vecs[k].addr, vecs[k].wdata);
            else if (vecs[k].wr_mode == 2'd2) wr_cs(1'b0, vecs[k].addr, vecs[k].wdata);
            rd(vecs[k].rd_cs, vecs[k].addr, d);
            check(vecs[k].name, d, vecs[k].exp);
        end
        step(1);
        check("idle_polarity", 16'(pwm_out), 16'h0007);

        host_rst = 1'b1;
        step(1);
        host_rst = 1'b0;

        // basic waveform: 3 high / 7 low, strobe every 10 clocks
        wr(ADDR_PRESCALE, 16'd0);
        wr(ADDR_PERIOD, 16'd9);
        wr(ADDR_DUTY_BASE, 16'd3);
        wr(ADDR_ENABLE, 16'd1);
        wr(ADDR_CTRL, 16'd1);
        measure(0, 1'b0, 3, 7, "wave_d3");
        strobe_gap(10, "strb_gap10");

        // duty change mid-period must wait for the next wrap
        wait_count(16'd5, "wait_cnt5");
        wr(ADDR_DUTY_BASE, 16'd7);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (pwm_out[0] !== 1'b0) bad++;
            step(1);
        end
        check("dupd_hold_low", 16'(bad), 16'd0);
        measure(0, 1'b0, 7, 3, "dupd_next");

        // duty write landing on the wrap edge
        wr(ADDR_DUTY_BASE, 16'd3);
        measure(0, 1'b0, 3, 7, "dupd_back");
        wait_count(16'd9, "wait_cnt9");
        wr(ADDR_DUTY_BASE, 16'd7);
        measure(0, 1'b0, 3, 7, "dwrap_first");
        measure(0, 1'b1, 7, 3, "dwrap_next");

        // prescaled: tick every 5 clocks, 4-tick period, 2 ticks high
        wr(ADDR_CTRL, 16'd0);
        wr(ADDR_PRESCALE, 16'd4);
        wr(ADDR_PERIOD, 16'd3);
        wr(ADDR_DUTY_BASE + 4'd1, 16'd2);
        wr(ADDR_ENABLE, 16'd2);
        wr(ADDR_CTRL, 16'd1);
        measure(1, 1'b0, 10, 10, "presc_d2");
        strobe_gap(20, "strb_gap20");

        // duty limits and polarity on channel 2
        wr(ADDR_CTRL, 16'd0);
        wr(ADDR_PRESCALE, 16'd0);
        wr(ADDR_PERIOD, 16'd3);
        wr(ADDR_ENABLE, 16'd4);
        wr(ADDR_DUTY_BASE + 4'd2, 16'd0);
        wr(ADDR_CTRL, 16'd1);
        check_const(2, 1'b0, "d0_low");
        wr(ADDR_DUTY_BASE + 4'd2, 16'hFFFF);
        step(10);
        check_const(2, 1'b1, "dmax_high");
        wr(ADDR_POLARITY, 16'd4);
        step(2);
        check_const(2, 1'b0, "dmax_inv");
        wr(ADDR_DUTY_BASE + 4'd2, 16'd0);
        step(10);
        check_const(2, 1'b1, "d0_inv");
        wr(ADDR_ENABLE, 16'd0);
        step(2);
        check_const(2, 1'b1, "dis_pol");

        // stop at count 6 with the output active
        wr(ADDR_POLARITY, 16'd0);
        wr(ADDR_CTRL, 16'd0);
        wr(ADDR_PERIOD, 16'd9);
        wr(ADDR_DUTY_BASE, 16'd8);
        wr(ADDR_ENABLE, 16'd1);
        wr(ADDR_CTRL, 16'd1);
        wait_count(16'd6, "wait_cnt6");
        wr(ADDR_CTRL, 16'd0);
        rd(1'b1, ADDR_COUNT, d);
        check("stop_count", d, 16'h0000);
        step(1);
        check("stop_idle", 16'(pwm_out), 16'h0000);

        // zero period: counter pinned at 0, strobe every tick
        wr(ADDR_PERIOD, 16'd0);
        wr(ADDR_POLARITY, 16'd4);
        wr(ADDR_CTRL, 16'd1);
        step(3);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (pwm_period_strb !== 1'b1) bad++;
            rd(1'b1, ADDR_COUNT, d);
            if (d !== 16'h0000) bad++;
            step(1);
        end
        check("per0_strb_count", 16'(bad), 16'd0);
        check("per0_out", 16'(pwm_out), 16'h0005);

        // reset while running
        host_rst = 1'b1;
        step(1);
        host_rst = 1'b0;
        check("rst_mid_out", 16'(pwm_out), 16'h0000);
        check("rst_mid_strb", 16'(pwm_period_strb), 16'h0000);
        for (int k = 0; k < n_rst_vecs; k++) begin
            rd(vecs[k].rd_cs, vecs[k].addr, d);
            check({"mid_", vecs[k].name}, d, vecs[k].exp);
        end
        step(3);
        check("rst_mid_strb_late", 16'(pwm_period_strb), 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
